spi_expander_host: RTL and testbench

Host-side SPI transaction controller that drives the 32-line SPI I/O expander. Accepts one register command (read or write, 7-bit register address, 8-bit data) on a valid/ready interface, serialises it as an address byte followed by a data byte on mosi, sequences the expander's `en` and `addrSel` lines, and returns the byte captured on miso. Sits directly upstream of the expander; its SPI outputs connect pin-for-pin to the expander's mosi/miso/clk/en/addrSel.

---
 rtl/spi_expander_pkg.sv | 8 +
 rtl/spi_sclk_timer.sv | 46 ++++
 rtl/spi_expander_host.sv | 148 ++++++++++++++
 tb/tb_spi_expander_host.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_expander_pkg.sv
// Shared state encoding and frame geometry for the SPI expander host.
package spi_expander_pkg;
    typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

    localparam int FRAME_BITS = 16;
    localparam int ADDR_BITS  = 8;
    localparam int RW_BIT     = 7;
endpackage

// File: rtl/spi_sclk_timer.sv
// Half-period counter: one-cycle rise/fall strobes every CLK_DIV cycles while enabled.
// Disabled it sits at the start of the low phase, so the first strobe after enable is always rise.
module spi_sclk_timer #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic rise,
    output logic fall
);
    localparam int              CW   = $clog2(CLK_DIV + 1);
    localparam logic [CW-1:0]   LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          phase_q, phase_d;
    logic          term;

    always_comb begin
        term    = (cnt_q == LAST);
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (!en) begin
            cnt_d   = '0;
            phase_d = 1'b0;
        end else if (term) begin
            cnt_d   = '0;
            phase_d = ~phase_q;
        end else begin
            cnt_d   = cnt_q + 1'b1;
        end
    end

    assign rise = en && !phase_q && term;
    assign fall = en &&  phase_q && term;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end
endmodule

// File: rtl/spi_expander_host.sv
// Serialises one register command as address+data bytes (mode 0, MSB first) and returns the miso data byte.
// Frame takes 32*CLK_DIV cycles plus GAP_CYCLES idle gap; cmd_ready only in IDLE, no queuing.
module spi_expander_host
    import spi_expander_pkg::*;
#(
    parameter int CLK_DIV    = 2,
    parameter int GAP_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_rw,
    input  logic [6:0] cmd_addr,
    input  logic [7:0] cmd_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       busy,
    output logic       spi_sclk,
    output logic       spi_mosi,
    input  logic       spi_miso,
    output logic       spi_en,
    output logic       spi_addr_sel
);
    localparam int            GW        = $clog2(GAP_CYCLES + 1);
    localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CYCLES - 1);
    localparam logic [3:0]    BIT_FIRST = 4'(FRAME_BITS - 1);
    localparam logic [3:0]    DATA_BITS = 4'(FRAME_BITS - ADDR_BITS);

    state_t                  state_q, state_d;
    logic [FRAME_BITS-1:0]   shreg_q, shreg_d;
    logic [3:0]              bit_cnt_q, bit_cnt_d;
    logic [GW-1:0]           gap_cnt_q, gap_cnt_d;
    logic [7:0]              rdata_q, rdata_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic                    sclk_q, sclk_d;
    logic                    mosi_q, mosi_d;
    logic                    en_q, en_d;
    logic                    addr_sel_q, addr_sel_d;
    logic [7:0]              addr_byte;
    logic                    timer_en, rise, fall;

    spi_sclk_timer #(.CLK_DIV(CLK_DIV)) u_timer (
        .clk   (clk),
        .rst_n (rst),
        .en    (timer_en),
        .rise  (rise),
        .fall  (fall)
    );

    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        bit_cnt_d   = bit_cnt_q;
        gap_cnt_d   = gap_cnt_q;
        rdata_d     = rdata_q;
        rsp_valid_d = 1'b0;
        sclk_d      = sclk_q;
        mosi_d      = mosi_q;
        en_d        = en_q;
        addr_sel_d  = addr_sel_q;
        timer_en    = (state_q == SHIFT);
        addr_byte   = {1'b0, cmd_addr};
        addr_byte[RW_BIT] = cmd_rw;

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    state_d    = SHIFT;
                    shreg_d    = {addr_byte, (cmd_rw ? 8'h00 : cmd_wdata)};
                    bit_cnt_d  = BIT_FIRST;
                    en_d       = 1'b1;
                    addr_sel_d = 1'b1;
                    mosi_d     = cmd_rw;
                    sclk_d     = 1'b0;
                end
            end
            SHIFT: begin
                if (rise) begin
                    sclk_d = 1'b1;
                    // Only the data byte is returned; address-phase samples are dropped.
                    if (bit_cnt_q < DATA_BITS) begin
                        rdata_d = {rdata_q[6:0], spi_miso};
                    end
                end
                if (fall) begin
                    sclk_d = 1'b0;
                    if (bit_cnt_q == 4'd0) begin
                        state_d     = GAP;
                        gap_cnt_d   = GAP_LAST;
                        en_d        = 1'b0;
                        mosi_d      = 1'b0;
                        addr_sel_d  = 1'b0;
                        rsp_valid_d = 1'b1;
                    end else begin
                        shreg_d    = shreg_q << 1;
                        mosi_d     = shreg_q[FRAME_BITS-2];
                        bit_cnt_d  = bit_cnt_q - 4'd1;
                        addr_sel_d = (bit_cnt_q > DATA_BITS);
                    end
                end
            end
            GAP: begin
                if (gap_cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            shreg_q     <= '0;
            bit_cnt_q   <= '0;
            gap_cnt_q   <= '0;
            rdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            sclk_q      <= 1'b0;
            mosi_q      <= 1'b0;
            en_q        <= 1'b0;
            addr_sel_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            bit_cnt_q   <= bit_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            rdata_q     <= rdata_d;
            rsp_valid_q <= rsp_valid_d;
            sclk_q      <= sclk_d;
            mosi_q      <= mosi_d;
            en_q        <= en_d;
            addr_sel_q  <= addr_sel_d;
        end
    end

    assign cmd_ready    = (state_q == IDLE);
    assign busy         = (state_q != IDLE);
    assign rsp_valid    = rsp_valid_q;
    assign rsp_rdata    = rdata_q;
    assign spi_sclk     = sclk_q;
    assign spi_mosi     = mosi_q;
    assign spi_en       = en_q;
    assign spi_addr_sel = addr_sel_q;
endmodule

// File: tb/tb_spi_expander_host.sv
// Bench for spi_expander_host: two instances (CLK_DIV=2/GAP=4 and CLK_DIV=1/GAP=1), a frame-level
// waveform model compared every cycle, an expander miso model, and directed literal checks.
module tb_spi_expander_host;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, cmd_valid, cmd_rw, spi_miso, sel;
    logic [6:0] cmd_addr;
    logic [7:0] cmd_wdata;
    logic       cv0, cv1;

    logic       d0_ready, d0_rv, d0_busy, d0_sclk, d0_mosi, d0_en, d0_as;
    logic       d1_ready, d1_rv, d1_busy, d1_sclk, d1_mosi, d1_en, d1_as;
    logic [7:0] d0_rdata, d1_rdata;

    assign cv0 = cmd_valid & ~sel;
    assign cv1 = cmd_valid &  sel;

    spi_expander_host #(.CLK_DIV(2), .GAP_CYCLES(4)) u_dut0 (
        .clk(clk), .rst(rst), .cmd_valid(cv0), .cmd_ready(d0_ready), .cmd_rw(cmd_rw),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .rsp_valid(d0_rv), .rsp_rdata(d0_rdata),
        .busy(d0_busy), .spi_sclk(d0_sclk), .spi_mosi(d0_mosi), .spi_miso(spi_miso),
        .spi_en(d0_en), .spi_addr_sel(d0_as));

    spi_expander_host #(.CLK_DIV(1), .GAP_CYCLES(1)) u_dut1 (
        .clk(clk), .rst(rst), .cmd_valid(cv1), .cmd_ready(d1_ready), .cmd_rw(cmd_rw),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .rsp_valid(d1_rv), .rsp_rdata(d1_rdata),
        .busy(d1_busy), .spi_sclk(d1_sclk), .spi_mosi(d1_mosi), .spi_miso(spi_miso),
        .spi_en(d1_en), .spi_addr_sel(d1_as));

    logic       o_ready, o_rv, o_busy, o_sclk, o_mosi, o_en, o_as;
    logic [7:0] o_rdata;
    assign o_ready = sel ? d1_ready : d0_ready;
    assign o_rv    = sel ? d1_rv    : d0_rv;
    assign o_busy  = sel ? d1_busy  : d0_busy;
    assign o_sclk  = sel ? d1_sclk  : d0_sclk;
    assign o_mosi  = sel ? d1_mosi  : d0_mosi;
    assign o_en    = sel ? d1_en    : d0_en;
    assign o_as    = sel ? d1_as    : d0_as;
    assign o_rdata = sel ? d1_rdata : d0_rdata;

    int pass_cnt = 0;
    int total_cnt = 0;
    int cyc = 0;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    endfunction

    // Model configuration and state
    int         cd = 2, gap = 4;
    logic [7:0] exp_byte = 8'h00;
    logic [7:0] exp_rd [2];
    int         T = 0, j, p, ph, idx;
    logic       active = 1'b0, m_ready = 1'b1, acc_flag = 1'b0, in_frame;
    logic [15:0] frame;
    logic       e_en, e_sclk, e_mosi, e_as, e_busy, e_rv;

    // Observation of the selected DUT
    int          nr = 0, en_cnt = 0, rv_cnt = 0, rv_edge = 0, rdy_edge = 0;
    logic [15:0] cap_mosi = '0, cap_as = '0;
    logic        prev_sclk_o = 1'b0, prev_rdy = 1'b1;

    initial begin
        exp_rd[0] = 8'h00;
        exp_rd[1] = 8'h00;
        forever begin
            @(posedge clk);
            cyc++;
            if (rst && cmd_valid && m_ready) begin
                T        = cyc;
                active   = 1'b1;
                frame    = {cmd_rw, cmd_addr, (cmd_rw ? 8'h00 : cmd_wdata)};
                acc_flag = 1'b1;
                nr = 0; en_cnt = 0; rv_cnt = 0; cap_mosi = '0; cap_as = '0;
            end
            #1;
            if (!rst) begin
                active = 1'b0; m_ready = 1'b1; exp_rd[0] = 8'h00; exp_rd[1] = 8'h00;
                chk("rst_en", o_en, 0);       chk("rst_sclk", o_sclk, 0);
                chk("rst_mosi", o_mosi, 0);   chk("rst_addr_sel", o_as, 0);
                chk("rst_busy", o_busy, 0);   chk("rst_ready", o_ready, 1);
                chk("rst_rsp_valid", o_rv, 0); chk("rst_rdata", o_rdata, 0);
            end else begin
                j = cyc - T;
                e_en = 0; e_sclk = 0; e_mosi = 0; e_as = 0; e_busy = 0; e_rv = 0; in_frame = 0;
                if (active && j < 32*cd) begin
                    in_frame = 1;
                    p  = j / (2*cd);
                    ph = j % (2*cd);
                    idx = 15 - p;
                    e_en = 1; e_busy = 1;
                    e_sclk = (ph >= cd);
                    e_mosi = frame[idx];
                    e_as = (idx >= 8);
                end else if (active && j < 32*cd + gap) begin
                    e_busy = 1;
                    if (j == 32*cd) begin
                        e_rv = 1;
                        exp_rd[sel] = exp_byte;
                    end
                end else begin
                    active = 1'b0;
                end
                m_ready = !active;
                chk("en", o_en, e_en);         chk("sclk", o_sclk, e_sclk);
                chk("mosi", o_mosi, e_mosi);   chk("addr_sel", o_as, e_as);
                chk("busy", o_busy, e_busy);   chk("ready", o_ready, !e_busy);
                chk("rsp_valid", o_rv, e_rv);
                if (!in_frame) chk("rdata", o_rdata, exp_rd[sel]);
            end
            if (o_sclk && !prev_sclk_o) begin
                nr++;
                cap_mosi = {cap_mosi[14:0], o_mosi};
                cap_as   = {cap_as[14:0], o_as};
            end
            if (o_en) en_cnt++;
            if (o_rv) begin rv_cnt++; rv_edge = cyc; end
            if (o_ready && !prev_rdy) rdy_edge = cyc;
            prev_sclk_o = o_sclk;
            prev_rdy    = o_ready;
        end
    end

    // Expander model: 0xFF during the address byte, exp_byte during the data byte, changing after each rise.
    int          nrise_s = 0;
    logic        prev_s = 1'b0;
    logic [15:0] word;
    initial begin
        spi_miso = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            if (!o_en) nrise_s = 0;
            else if (o_sclk && !prev_s) nrise_s++;
            prev_s = o_sclk;
            word = {8'hFF, exp_byte};
            spi_miso = (nrise_s < 16) ? word[15 - nrise_s] : 1'b0;
        end
    end

    task automatic wait_accept();
        logic ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk);
            #2;
            if (acc_flag) begin ok = 1'b1; break; end
        end
        chk("accept_timeout", ok, 1);
    endtask

    task automatic wait_idle();
        logic ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (m_ready && o_ready) begin ok = 1'b1; break; end
        end
        chk("idle_timeout", ok, 1);
    endtask

    task automatic send(input logic rw, input logic [6:0] a, input logic [7:0] d);
        @(negedge clk);
        cmd_rw = rw; cmd_addr = a; cmd_wdata = d; cmd_valid = 1'b1; acc_flag = 1'b0;
        wait_accept();
        @(negedge clk);
        cmd_valid = 1'b0; cmd_rw = ~rw; cmd_addr = ~a; cmd_wdata = ~d;
    endtask

    int t1;

    initial begin
        rst = 1'b0; cmd_valid = 1'b0; cmd_rw = 1'b0; cmd_addr = '0; cmd_wdata = '0; sel = 1'b0;
        #2;
        chk("por_ready", o_ready, 1);
        chk("por_en", o_en, 0);
        chk("por_rdata", o_rdata, 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (5) @(negedge clk);
        chk("idle_no_sclk", nr, 0);
        chk("idle_ready", o_ready, 1);

        // Write 0x05 <- 0xA5
        exp_byte = 8'h96;
        send(1'b0, 7'h05, 8'hA5);
        wait_idle();
        chk("wr_mosi_bits", cap_mosi, 16'h05A5);
        chk("wr_addr_sel", cap_as, 16'hFF00);
        chk("wr_en_cycles", en_cnt, 64);
        chk("wr_rsp_count", rv_cnt, 1);
        chk("wr_rsp_time", rv_edge - T, 64);
        chk("wr_ready_time", rdy_edge - T, 68);
        chk("wr_rdata", o_rdata, 8'h96);

        // Read 0x02, expander returns 0x3C
        exp_byte = 8'h3C;
        send(1'b1, 7'h02, 8'h77);
        wait_idle();
        chk("rd_mosi_bits", cap_mosi, 16'h8200);
        chk("rd_rdata", o_rdata, 8'h3C);
        chk("rd_rsp_count", rv_cnt, 1);

        // Back-to-back with cmd_valid toggled mid-frame
        exp_byte = 8'h81;
        @(negedge clk);
        cmd_rw = 1'b0; cmd_addr = 7'h11; cmd_wdata = 8'h5A; cmd_valid = 1'b1; acc_flag = 1'b0;
        wait_accept();
        t1 = T; acc_flag = 1'b0;
        @(negedge clk);
        cmd_addr = 7'h22; cmd_wdata = 8'hC3;
        repeat (3) @(negedge clk) cmd_valid = ~cmd_valid;
        @(negedge clk) cmd_valid = 1'b1;
        wait_accept();
        chk("b2b_accept_gap", T - t1, 69);
        chk("b2b_dut_ready_edge", rdy_edge - t1, 68);
        @(negedge clk) cmd_valid = 1'b0;
        wait_idle();
        chk("b2b_second_mosi", cap_mosi, 16'h22C3);
        chk("b2b_rdata", o_rdata, 8'h81);

        // Mid-frame reset after rise 10
        exp_byte = 8'hE7;
        send(1'b1, 7'h33, 8'h00);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (nr >= 11) break;
        end
        chk("abort_reached_rise10", nr, 11);
        #3 rst = 1'b0;
        #1;
        chk("abort_en", o_en, 0);
        chk("abort_sclk", o_sclk, 0);
        chk("abort_busy", o_busy, 0);
        chk("abort_ready", o_ready, 1);
        chk("abort_rdata", o_rdata, 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        chk("abort_no_rsp", rv_cnt, 0);
        exp_byte = 8'h18;
        send(1'b0, 7'h5C, 8'h96);
        wait_idle();
        chk("post_abort_mosi", cap_mosi, 16'h5C96);
        chk("post_abort_en_cycles", en_cnt, 64);
        chk("post_abort_rsp", rv_cnt, 1);

        // CLK_DIV=1, GAP_CYCLES=1 instance
        @(negedge clk);
        sel = 1'b1; cd = 1; gap = 1;
        exp_byte = 8'h42;
        send(1'b0, 7'h7F, 8'hFF);
        wait_idle();
        chk("fast_mosi_bits", cap_mosi, 16'h7FFF);
        chk("fast_addr_sel", cap_as, 16'hFF00);
        chk("fast_en_cycles", en_cnt, 32);
        chk("fast_rsp_time", rv_edge - T, 32);
        chk("fast_ready_time", rdy_edge - T, 33);
        chk("fast_rdata", o_rdata, 8'h42);

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end
endmodule
